// File: rtl/not_not_pkg.sv
// Shared types and defaults for the Not Not round controller.
package not_not_pkg;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 150_000_000;
  localparam int unsigned DEF_MAX_LIVES      = 3;
  localparam int unsigned ANSWER_W           = 4;
  localparam int unsigned LIVES_W            = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADVANCE   = 3'd1,
    S_SETTLE    = 3'd2,
    S_WAIT      = 3'd3,
    S_JUDGE     = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

endpackage

// File: rtl/round_timer.sv
// Down-counter for the answer window; zero goes high one cycle after the count
// has sat at 0 while still being decremented, i.e. the window has fully expired.
module round_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      zero  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      zero  <= 1'b0;
    end else if (dec) begin
      if (count == '0) zero <= 1'b1;
      else             count <= count - W'(1);
    end
  end

endmodule

// File: rtl/not_not_round_ctrl.sv
// Round sequencing for the Not Not game: prompt advance, timed answer window,
// judging, score/lives bookkeeping and game-over handling.
module not_not_round_ctrl
  import not_not_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned MAX_LIVES      = DEF_MAX_LIVES,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                answer_valid,
  input  logic [ANSWER_W-1:0] answer,
  input  logic [ANSWER_W-1:0] expected,
  output logic                prompt_enable,
  output logic                playing,
  output logic                result_valid,
  output logic                result_correct,
  output logic [SCORE_W-1:0]  score,
  output logic [LIVES_W-1:0]  lives,
  output logic                game_over
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t state, next_state;
  logic   tmr_zero;
  logic   judge_c;
  logic   verdict_c;
  logic   new_game_c;
  logic   prompt_enable_d, playing_d, result_valid_d, game_over_d;

  round_timer #(.W(TW)) u_timer (
    .clk      (clock),
    .rst_n    (resetn),
    .load     (state == S_SETTLE),
    .load_val (TW'(TIMEOUT_CYCLES - 1)),
    .dec      (state == S_WAIT),
    .zero     (tmr_zero)
  );

  // An answer in the final window cycle wins over the timeout.
  assign judge_c    = (state == S_WAIT) && (answer_valid || tmr_zero);
  assign verdict_c  = answer_valid && (answer == expected);
  assign new_game_c = ((state == S_IDLE) || (state == S_GAME_OVER)) && start;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (start) next_state = S_ADVANCE;
      S_ADVANCE:   next_state = S_SETTLE;
      S_SETTLE:    next_state = S_WAIT;
      S_WAIT:      if (judge_c) next_state = S_JUDGE;
      S_JUDGE:     next_state = (lives == '0) ? S_GAME_OVER : S_ADVANCE;
      S_GAME_OVER: if (start) next_state = S_ADVANCE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Output values for the upcoming state, registered below.
  always_comb begin
    prompt_enable_d = 1'b0;
    playing_d       = 1'b0;
    result_valid_d  = 1'b0;
    game_over_d     = 1'b0;
    case (next_state)
      S_ADVANCE:   prompt_enable_d = 1'b1;
      S_WAIT:      playing_d       = 1'b1;
      S_JUDGE:     result_valid_d  = 1'b1;
      S_GAME_OVER: game_over_d     = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prompt_enable <= 1'b0;
      playing       <= 1'b0;
      result_valid  <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      prompt_enable <= prompt_enable_d;
      playing       <= playing_d;
      result_valid  <= result_valid_d;
      game_over     <= game_over_d;
    end
  end

  // Score/lives update together with the verdict so they are valid with result_valid.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      score          <= '0;
      lives          <= '0;
      result_correct <= 1'b0;
    end else if (new_game_c) begin
      score <= '0;
      lives <= LIVES_W'(MAX_LIVES);
    end else if (judge_c) begin
      result_correct <= verdict_c;
      if (verdict_c) begin
        if (score != '1) score <= score + SCORE_W'(1);
      end else if (lives != '0) begin
        lives <= lives - LIVES_W'(1);
      end
    end
  end

endmodule
